// File: rtl/morph_seq_ctrl_if.sv
// Pixel source/sink, frame control and datapath signals for morph_seq_ctrl.
// The slave modport is the sequencer; the master side is its environment.
interface morph_seq_ctrl_if;
   logic       start;
   logic       op_dilate;
   logic       busy;
   logic       pix_in;
   logic       pix_in_valid;
   logic       pix_in_ready;
   logic       dp_rst;
   logic       dp_a;
   logic       dp_conf;
   logic       dp_out;
   logic       pix_out;
   logic       pix_out_valid;
   logic       pix_out_border;
   logic [7:0] out_row;
   logic [7:0] out_col;
   logic       done;
   logic       underflow;

   modport master (
      output start, op_dilate, pix_in, pix_in_valid, dp_out,
      input  busy, pix_in_ready, dp_rst, dp_a, dp_conf, pix_out, pix_out_valid,
             pix_out_border, out_row, out_col, done, underflow
   );

   modport slave (
      input  start, op_dilate, pix_in, pix_in_valid, dp_out,
      output busy, pix_in_ready, dp_rst, dp_a, dp_conf, pix_out, pix_out_valid,
             pix_out_border, out_row, out_col, done, underflow
   );
endinterface

// File: rtl/morph_seq_ctrl.sv
// Frame sequencer for a free-running 3x3 binary morphology datapath: clears it,
// streams one frame plus LAT flush slots, and tags each result with position.
module morph_seq_ctrl #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int LAT    = 258,
   parameter int CW     = 18
) (
   input logic             clk,
   input logic             rst,
   morph_seq_ctrl_if.slave io
);
   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

   localparam logic [CW-1:0] G_LAST_PIX  = CW'(WIDTH * HEIGHT - 1);
   localparam logic [CW-1:0] G_FIRST_OUT = CW'(LAT);
   localparam logic [CW-1:0] G_LAST_OUT  = CW'(LAT + WIDTH * HEIGHT - 1);
   localparam logic [CW-1:0] G_MAX       = {CW{1'b1}};
   localparam logic [CW-1:0] G_ONE       = CW'(1);
   localparam logic [7:0]    COL_LAST    = 8'(WIDTH - 1);
   localparam logic [7:0]    ROW_LAST    = 8'(HEIGHT - 1);

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] g_r;
   logic [7:0]    row_r;
   logic [7:0]    col_r;
   logic          conf_r;
   logic          uflow_r;
   logic          valid_s;
   logic          in_seq_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; frame length is fixed by g, never by input availability
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (io.start) state_s = CLEAR;
            else          state_s = IDLE;
         end
         CLEAR:  state_s = STREAM;
         STREAM: begin
            if (g_r == G_LAST_PIX) state_s = FLUSH;
            else                   state_s = STREAM;
         end
         FLUSH: begin
            if (g_r == G_LAST_OUT) state_s = DONE;
            else                   state_s = FLUSH;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign in_seq_s = (state_r == STREAM) || (state_r == FLUSH);
   assign valid_s  = in_seq_s && (g_r >= G_FIRST_OUT) && (g_r <= G_LAST_OUT);

   // Sequence counter: runs through STREAM and FLUSH, saturates, idles at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         g_r <= '0;
      end else if (in_seq_s) begin
         if (g_r != G_MAX) g_r <= g_r + G_ONE;
         else              g_r <= g_r;
      end else begin
         g_r <= '0;
      end
   end

   // Mode latch and sticky underflow, both rearmed by an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         conf_r  <= 1'b0;
         uflow_r <= 1'b0;
      end else if ((state_r == IDLE) && io.start) begin
         conf_r  <= io.op_dilate;
         uflow_r <= 1'b0;
      end else if ((state_r == STREAM) && !io.pix_in_valid) begin
         conf_r  <= conf_r;
         uflow_r <= 1'b1;
      end else begin
         conf_r  <= conf_r;
         uflow_r <= uflow_r;
      end
   end

   // Result position: restarts each frame, advances only on valid results
   always_ff @(posedge clk) begin
      if (rst || (state_r == CLEAR)) begin
         row_r <= 8'd0;
         col_r <= 8'd0;
      end else if (valid_s) begin
         if (col_r == COL_LAST) begin
            col_r <= 8'd0;
            if (row_r == ROW_LAST) row_r <= 8'd0;
            else                   row_r <= row_r + 8'd1;
         end else begin
            col_r <= col_r + 8'd1;
            row_r <= row_r;
         end
      end else begin
         row_r <= row_r;
         col_r <= col_r;
      end
   end

   assign io.busy           = (state_r != IDLE);
   assign io.pix_in_ready   = (state_r == STREAM);
   assign io.dp_rst         = rst || (state_r == CLEAR);
   assign io.dp_a           = (state_r == STREAM) && io.pix_in_valid && io.pix_in;
   assign io.dp_conf        = conf_r;
   assign io.pix_out        = io.dp_out;
   assign io.pix_out_valid  = valid_s;
   assign io.pix_out_border = valid_s && ((row_r == 8'd0) || (row_r == ROW_LAST) ||
                                          (col_r == 8'd0) || (col_r == COL_LAST));
   assign io.out_row        = row_r;
   assign io.out_col        = col_r;
   assign io.done           = (state_r == DONE);
   assign io.underflow      = uflow_r;
endmodule

// File: tb/tb_morph_seq_ctrl.sv
// Bench for morph_seq_ctrl on a reduced frame, with a cross-shaped morphology
// datapath stand-in and a per-frame expected image computed from the input plan.
module tb_morph_seq_ctrl;
   localparam int W    = 16;
   localparam int H    = 8;
   localparam int L    = W + 2;
   localparam int NPIX = W * H;
   localparam int TEND = 1 + NPIX + L;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic img    [NPIX];
   logic refimg [NPIX];
   logic hist   [NPIX];
   int   dp_n = 0;
   logic dp_out_q = 1'b0;

   morph_seq_ctrl_if io ();

   morph_seq_ctrl #(.WIDTH(W), .HEIGHT(H), .LAT(L), .CW(10)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Cross-shaped structuring element; neighbours outside the frame do not contribute
   function automatic logic morph_at(input logic a [NPIX], input int k, input logic dil);
      int   r, c, rr, cc;
      logic acc;
      r   = k / W;
      c   = k % W;
      acc = a[k];
      for (int d = 0; d < 4; d++) begin
         rr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
         cc = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
         if (rr >= 0 && rr < H && cc >= 0 && cc < W)
            acc = dil ? (acc | a[rr * W + cc]) : (acc & a[rr * W + cc]);
      end
      return acc;
   endfunction

   // Datapath stand-in: free-running, cleared by dp_rst, centred result LAT slots later
   always @(posedge clk) begin
      if (io.dp_rst) begin
         dp_n     <= 0;
         dp_out_q <= 1'b0;
      end else begin
         if (dp_n < NPIX) hist[dp_n] <= io.dp_a;
         dp_n <= dp_n + 1;
         if (dp_n + 1 >= L && dp_n + 1 - L < NPIX)
            dp_out_q <= morph_at(hist, dp_n + 1 - L, io.dp_conf);
         else
            dp_out_q <= 1'b0;
      end
   end
   assign io.dp_out = dp_out_q;

   function automatic logic [8:0] ctrl_vec();
      return {io.busy, io.pix_in_ready, io.dp_rst, io.dp_a, io.dp_conf,
              io.pix_out_valid, io.pix_out_border, io.done, io.underflow};
   endfunction

   // pat: 0 single pixel at (1,1), 1 all ones, 2 random
   task automatic run_frame(input logic dil, input int pat, input int gap_at, input int rst_at,
                            input int spur_at, input bit pre, input int chain);
      logic [8:0]  exp_c;
      logic [23:0] exp_p;
      logic        ev, eb, in_stream, in_gap;
      int          j, tmax, nvalid, ndone, nborder;
      for (int i = 0; i < NPIX; i++) begin
         case (pat)
            0:       img[i] = (i == W + 1);
            1:       img[i] = 1'b1;
            default: img[i] = 1'($urandom_range(0, 1));
         endcase
         if (gap_at >= 0 && i >= gap_at && i < gap_at + 3) img[i] = 1'b0;
      end
      for (int i = 0; i < NPIX; i++) refimg[i] = morph_at(img, i, dil);
      if (!pre) begin
         @(negedge clk);
         io.start     = 1'b1;
         io.op_dilate = dil;
      end
      @(posedge clk);
      nvalid  = 0;
      ndone   = 0;
      nborder = 0;
      tmax    = (rst_at >= 0) ? rst_at + 5 : ((chain >= 0) ? TEND + 1 : TEND + 2);
      for (int t = 0; t <= tmax; t++) begin
         @(negedge clk);
         in_stream        = (t >= 1 && t <= NPIX);
         in_gap           = in_stream && gap_at >= 0 && (t - 1) >= gap_at && (t - 1) < gap_at + 3;
         io.start         = (t == spur_at) || (t == TEND);
         io.op_dilate     = ~dil;
         io.pix_in_valid  = in_stream ? !in_gap : 1'($urandom_range(0, 1));
         io.pix_in        = (in_stream && !in_gap) ? img[t - 1] : 1'($urandom_range(0, 1));
         rst              = (t == rst_at);
         #1;
         j  = t - 1 - L;
         ev = (t >= L + 1 && t <= L + NPIX);
         if (rst_at >= 0 && t > rst_at) begin
            exp_c = 9'd0;
            ev    = 1'b0;
         end else begin
            eb    = ev && ((j / W) == 0 || (j / W) == H - 1 || (j % W) == 0 || (j % W) == W - 1);
            exp_c = {t <= TEND, in_stream, (t == 0) || (t == rst_at),
                     in_stream ? img[t - 1] : 1'b0, dil, ev, eb, t == TEND,
                     gap_at >= 0 && t > gap_at + 1};
         end
         check("ctrl", 32'(ctrl_vec()), 32'(exp_c));
         if (ev) begin
            exp_p = {7'd0, refimg[j], 8'(j / W), 8'(j % W)};
            check("pix", {15'd0, io.pix_out, io.out_row, io.out_col}, 32'(exp_p));
         end
         if (io.pix_out_valid) nvalid++;
         if (io.pix_out_valid && io.pix_out_border) nborder++;
         if (io.done) ndone++;
      end
      rst = 1'b0;
      check("done_cnt", ndone, (rst_at >= 0) ? 0 : 1);
      if (rst_at < 0) check("valid_cnt", nvalid, NPIX);
      if (pat == 1 && rst_at < 0) check("border_cnt", nborder, 2 * W + 2 * H - 4);
      if (chain >= 0) begin
         io.start     = 1'b1;
         io.op_dilate = 1'(chain);
      end else begin
         io.start = 1'b0;
      end
   endtask

   initial begin
      rst             = 1'b1;
      io.start        = 1'b0;
      io.op_dilate    = 1'b0;
      io.pix_in       = 1'b0;
      io.pix_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", 32'(ctrl_vec()), 32'(9'b001000000));
      check("rst_pos", {16'd0, io.out_row, io.out_col}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_ctrl", 32'(ctrl_vec()), 32'd0);

      // reset and start together: reset wins
      @(negedge clk);
      rst          = 1'b1;
      io.start     = 1'b1;
      io.op_dilate = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      io.start = 1'b0;
      #1;
      check("rst_start", 32'(ctrl_vec()), 32'd0);

      run_frame(1'b1, 0, -1, -1, -1, 1'b0, -1);
      run_frame(1'b0, 1, -1, -1, -1, 1'b0, -1);
      run_frame(1'b1, 2, 40, -1, 60, 1'b0, -1);
      run_frame(1'b0, 2, -1, 51, -1, 1'b0, -1);
      run_frame(1'b1, 2, -1, -1, 30, 1'b0, 0);
      run_frame(1'b0, 2, -1, -1, -1, 1'b1, -1);

      @(negedge clk);
      check("final_idle", 32'(ctrl_vec()), 32'(9'b000000000));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
